// File: rtl/rv32i_types_pkg.sv
// Shared RV32 pipeline types used by decode and the EX-stage units.
// Contents:
//   muldiv_funct3_t - M-extension funct3 encodings
//   muldiv_state_t  - multiply/divide unit FSM states
//   MULDIV_FUNCT7   - funct7 value that selects the M extension in decode
//   control_word_t  - decoded control bits carried down the pipeline
//   helper functions that classify an M-extension funct3
package rv32i_types;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic muldiv;     // set by decode when funct7 == MULDIV_FUNCT7 on an OP instruction
  } control_word_t;

  // Operand a is treated as two's complement.
  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Operand b is treated as two's complement (MULHSU keeps b unsigned).
  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic op_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_divider_core.sv
// Restoring-divide step datapath. Purely combinational: retires
// BITS_PER_CYCLE quotient bits from the current partial remainder and
// quotient shift register. The caller owns the registers.
// Ports:
//   rem_in   - partial remainder (XLEN+1 bits)
//   quo_in   - quotient shift register; dividend bits shift out of the MSB
//   divisor  - divisor magnitude
//   rem_out  - partial remainder after BITS_PER_CYCLE steps
//   quo_out  - quotient register after BITS_PER_CYCLE steps
module ex_divider_core #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  always_comb begin
    rem_out = rem_in;
    quo_out = quo_in;
    trial   = '0;
    diff    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      // The remainder stays below the divisor, so its top bit is always 0
      // and the shifted trial value fits in XLEN+1 bits.
      trial = {rem_out[XLEN-1:0], quo_out[XLEN-1]};
      diff  = trial - {1'b0, divisor};
      if (!diff[XLEN]) begin
        rem_out = diff;
        quo_out = {quo_out[XLEN-2:0], 1'b1};
      end else begin
        rem_out = trial;
        quo_out = {quo_out[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiply: shift-add on operand magnitudes with a 2*XLEN accumulator.
// Divide: restoring divide (ex_divider_core) on operand magnitudes.
// Signs are fixed up on the final CALC edge. Divide-by-zero and the
// signed-overflow divide finish straight from IDLE.
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   start, funct3     - request and M-extension op, sampled when ready=1
//   rs1_val, rs2_val  - operands a and b
//   flush             - synchronous abort, highest priority
//   ack               - downstream took the result
//   ready, busy, done - FSM status; result valid while done=1
//   result            - registered result
//   dbg_state         - current FSM state for observation
//
// Handshake: a request is accepted on a rising edge where start=1,
// ready=1 and flush=0. A result is offered while done=1 and stays stable
// until a rising edge with ack=1 (or flush=1) returns the unit to IDLE.
module ex_muldiv_unit
  import rv32i_types::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  input  logic            ack,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output muldiv_state_t   dbg_state
);

  localparam int            ITER      = XLEN / BITS_PER_CYCLE;
  localparam int            CW        = $clog2(ITER);
  localparam logic [CW-1:0] ITER_LAST = CW'(ITER - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t    state_q;
  muldiv_funct3_t   f3_q;
  logic [XLEN-1:0]  a_mag_q;
  logic [XLEN-1:0]  b_mag_q;
  logic             neg_q;      // negate product / quotient
  logic             rem_neg_q;  // remainder takes sign of a
  logic [CW-1:0]    cnt_q;
  logic [2*XLEN-1:0] mul_acc_q; // {partial product, remaining multiplier bits}
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  result_q;

  // Request decode on the raw inputs.
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_by_zero, div_ovf;

  assign a_sgn       = op_a_signed(funct3) & rs1_val[XLEN-1];
  assign b_sgn       = op_b_signed(funct3) & rs2_val[XLEN-1];
  assign a_abs       = a_sgn ? -rs1_val : rs1_val;
  assign b_abs       = b_sgn ? -rs2_val : rs2_val;
  assign div_by_zero = op_is_div(funct3) && (rs2_val == '0);
  assign div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                       (rs1_val == INT_MIN) && (rs2_val == '1);

  // Multiply step: add multiplicand when the multiplier LSB is set, then
  // shift the whole accumulator right, carry included.
  logic [2*XLEN-1:0] mul_nx;
  logic [XLEN:0]     mul_sum;

  always_comb begin
    mul_nx  = mul_acc_q;
    mul_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mul_nx[0]) mul_sum = {1'b0, mul_nx[2*XLEN-1:XLEN]} + {1'b0, a_mag_q};
      else           mul_sum = {1'b0, mul_nx[2*XLEN-1:XLEN]};
      mul_nx = {mul_sum, mul_nx[XLEN-1:1]};
    end
  end

  // Divide step.
  logic [XLEN:0]   div_rem_nx;
  logic [XLEN-1:0] div_quo_nx;

  ex_divider_core #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_div (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(b_mag_q),
    .rem_out(div_rem_nx),
    .quo_out(div_quo_nx)
  );

  // Sign fix-up and result selection for the final CALC edge.
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  assign mul_prod = neg_q ? -mul_nx : mul_nx;
  assign quo_fix  = neg_q ? -div_quo_nx : div_quo_nx;
  assign rem_fix  = rem_neg_q ? -div_rem_nx[XLEN-1:0] : div_rem_nx[XLEN-1:0];

  always_comb begin
    calc_res = '0;
    case (f3_q)
      F3_MUL:                        calc_res = mul_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  calc_res = mul_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               calc_res = quo_fix;
      default:                       calc_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      f3_q      <= F3_MUL;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      mul_acc_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            f3_q      <= muldiv_funct3_t'(funct3);
            a_mag_q   <= a_abs;
            b_mag_q   <= b_abs;
            neg_q     <= a_sgn ^ b_sgn;
            rem_neg_q <= a_sgn;
            cnt_q     <= '0;
            // Only the path the op uses is loaded; the other keeps its value.
            if (op_is_div(funct3)) begin
              rem_q <= '0;
              quo_q <= a_abs;
            end else begin
              mul_acc_q <= {{XLEN{1'b0}}, b_abs};
            end
            if (div_by_zero) begin
              result_q <= ((funct3 == F3_DIV) || (funct3 == F3_DIVU)) ? '1 : rs1_val;
              state_q  <= DONE;
            end else if (div_ovf) begin
              result_q <= (funct3 == F3_DIV) ? INT_MIN : '0;
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_is_div(f3_q)) begin
            rem_q <= div_rem_nx;
            quo_q <= div_quo_nx;
          end else begin
            mul_acc_q <= mul_nx;
          end
          if (cnt_q == ITER_LAST) begin
            result_q <= calc_res;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (ack) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import rv32i_types::*;

  localparam int ITER = 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        ack = 1'b1;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic        ready, busy, done;
  logic [31:0] result;
  muldiv_state_t dbg_state;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .flush    (flush),
    .ack      (ack),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: RV32M semantics with wide integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    pv = '0;
    case (f3)
      3'd0: begin pv = sa * sb; return pv[31:0]; end
      3'd1: begin pv = sa * sb; return pv[63:32]; end
      3'd2: begin pv = sa * ub; return pv[63:32]; end
      3'd3: begin pv = {32'b0, a} * {32'b0, b}; return pv[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pv = sa / sb;  // wide division: -2^31 / -1 does not overflow here
        return pv[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        pv = sa % sb;
        return pv[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (f3[2] && b == 0) ||
           ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // ---------------- driver ----------------
  // Issues one request with ack held high, then checks result, the number
  // of edges after the sampling edge until done, busy duration and return to idle.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int          j;
    int          busy_cnt;
    int          exp_lat;
    logic [31:0] e;
    exp_q.push_back(exp);
    exp_lat = is_special(f3, a, b) ? 0 : ITER;
    @(negedge clk);
    funct3 = f3; rs1_val = a; rs2_val = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    j = 0; busy_cnt = 0;
    while (1) begin
      if (busy && !ready) busy_cnt++;
      if (done || j >= 200) break;
      @(negedge clk);
      j++;
    end
    e = exp_q.pop_front();
    chk({name, "_result"}, result, e);
    chk({name, "_latency"}, 32'(j), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat + 1));
    @(negedge clk);
    chk({name, "_idle_after"}, {30'b0, ready, done}, 32'b10);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int          j;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    vecs[0]  = '{"mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{"mulh_min_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{"mulhu_max",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{"mulhsu_m1_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{"div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{"divu_100_7",    3'd5, 32'd100,       32'd7,         32'd14};
    vecs[7]  = '{"remu_100_7",    3'd7, 32'd100,       32'd7,         32'd2};
    vecs[8]  = '{"div_7_m2",      3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[9]  = '{"rem_7_m2",      3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1};
    vecs[10] = '{"div_5_0",       3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[11] = '{"remu_5_0",      3'd7, 32'd5,         32'd0,         32'd5};
    vecs[12] = '{"div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[13] = '{"rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'b0, ready}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < 14; i++)
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

    // ---- flush during the 10th CALC cycle ----
    @(negedge clk);
    funct3 = 3'd0; rs1_val = 32'd7; rs2_val = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;             // now in CALC cycle 1
    repeat (9) @(negedge clk); // now in CALC cycle 10
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", {31'b0, ready}, 32'd1);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    run_op("after_flush", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

    // ---- flush and start in the same IDLE cycle ----
    @(negedge clk);
    funct3 = 3'd5; rs1_val = 32'd5; rs2_val = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("flush_start_idle", {30'b0, ready, done}, 32'b10);
      @(negedge clk);
    end

    // ---- hold in DONE with ack low ----
    ack = 1'b0;
    funct3 = 3'd5; rs1_val = 32'd100; rs2_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (!done && j < 200) begin
      @(negedge clk);
      j++;
    end
    chk("hold_latency", 32'(j), 32'(ITER));
    for (int c = 0; c < 3; c++) begin
      chk("hold_done", {31'b0, done}, 32'd1);
      chk("hold_result", result, 32'd14);
      chk("hold_ready", {31'b0, ready}, 32'd0);
      if (c == 1) begin
        funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    chk("hold_ack_idle", {30'b0, ready, done}, 32'b10);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_no_queue", {30'b0, ready, done}, 32'b10);
    end

    // ---- randomized against the reference model ----
    for (int n = 0; n < 40; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op($sformatf("rnd%0d_f%0d_%h_%h", n, rf3, ra, rb), rf3, ra, rb, ref_model(rf3, ra, rb));
    end

    // ---- asynchronous reset mid-CALC ----
    @(negedge clk);
    funct3 = 3'd1; rs1_val = 32'h1234_5678; rs2_val = 32'h9ABC_DEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ready", {31'b0, ready}, 32'd1);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("after_reset", 3'd7, 32'd100, 32'd7, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
